// File: rtl/lemming_array_fsm.sv
// NUM_LEM independent lemming walker FSMs with saturating fall counters and splat detection.
// Optional macro LEMMING_REVIVE_EN adds a per-channel revive input that brings a splatted lemming back.
module lemming_array_fsm #(
    parameter int NUM_LEM    = 4,
    parameter int FALL_LIMIT = 20
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic [NUM_LEM-1:0] bump_left,
    input  logic [NUM_LEM-1:0] bump_right,
    input  logic [NUM_LEM-1:0] ground,
    input  logic [NUM_LEM-1:0] dig,
`ifdef LEMMING_REVIVE_EN
    input  logic [NUM_LEM-1:0] revive,
`endif
    output logic [NUM_LEM-1:0] walk_left,
    output logic [NUM_LEM-1:0] walk_right,
    output logic [NUM_LEM-1:0] aaah,
    output logic [NUM_LEM-1:0] digging
);

    localparam int CNT_W = $clog2(FALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_LIMIT);

    typedef enum logic [2:0] {
        S_WALK_L = 3'd0,
        S_WALK_R = 3'd1,
        S_FALL_L = 3'd2,
        S_FALL_R = 3'd3,
        S_DIG_L  = 3'd4,
        S_DIG_R  = 3'd5,
        S_SPLAT  = 3'd6
    } state_t;

    state_t           r_state      [NUM_LEM];
    state_t           w_state_nxt  [NUM_LEM];
    logic [CNT_W-1:0] r_fall_cnt   [NUM_LEM];
    logic [CNT_W-1:0] w_fall_cnt_nxt [NUM_LEM];

    logic [NUM_LEM-1:0] w_revive;

`ifdef LEMMING_REVIVE_EN
    assign w_revive = revive;
`else
    assign w_revive = '0;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_LEM; i++) begin
                r_state[i]    <= S_WALK_L;
                r_fall_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEM; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_fall_cnt[i] <= w_fall_cnt_nxt[i];
            end
        end
    end

    // Priority inside each walking state is fall, then dig, then bump.
    always_comb begin
        for (int i = 0; i < NUM_LEM; i++) begin
            w_state_nxt[i]    = r_state[i];
            w_fall_cnt_nxt[i] = '0;
            case (r_state[i])
                S_WALK_L: begin
                    if (!ground[i])         w_state_nxt[i] = S_FALL_L;
                    else if (dig[i])        w_state_nxt[i] = S_DIG_L;
                    else if (bump_left[i])  w_state_nxt[i] = S_WALK_R;
                end
                S_WALK_R: begin
                    if (!ground[i])         w_state_nxt[i] = S_FALL_R;
                    else if (dig[i])        w_state_nxt[i] = S_DIG_R;
                    else if (bump_right[i]) w_state_nxt[i] = S_WALK_L;
                end
                S_DIG_L: begin
                    if (!ground[i])         w_state_nxt[i] = S_FALL_L;
                end
                S_DIG_R: begin
                    if (!ground[i])         w_state_nxt[i] = S_FALL_R;
                end
                S_FALL_L, S_FALL_R: begin
                    // The counter holds the FALL cycles already completed, so >= LIMIT
                    // on landing means this is at least cycle FALL_LIMIT+1 of the fall.
                    w_fall_cnt_nxt[i] = (r_fall_cnt[i] >= LIMIT) ? LIMIT
                                                                 : r_fall_cnt[i] + CNT_W'(1);
                    if (ground[i]) begin
                        if (r_fall_cnt[i] >= LIMIT)      w_state_nxt[i] = S_SPLAT;
                        else if (r_state[i] == S_FALL_L) w_state_nxt[i] = S_WALK_L;
                        else                             w_state_nxt[i] = S_WALK_R;
                    end
                end
                S_SPLAT: begin
                    if (w_revive[i])        w_state_nxt[i] = S_WALK_L;
                end
                default: begin
                    w_state_nxt[i] = S_WALK_L;
                end
            endcase
        end
    end

    always_comb begin
        walk_left  = '0;
        walk_right = '0;
        aaah       = '0;
        digging    = '0;
        for (int i = 0; i < NUM_LEM; i++) begin
            walk_left[i]  = (r_state[i] == S_WALK_L);
            walk_right[i] = (r_state[i] == S_WALK_R);
            aaah[i]       = (r_state[i] == S_FALL_L) || (r_state[i] == S_FALL_R);
            digging[i]    = (r_state[i] == S_DIG_L)  || (r_state[i] == S_DIG_R);
        end
    end

endmodule
